// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction-memory interface.
// Receives a program image as a byte stream (4-byte little-endian word count N,
// then N little-endian words) and writes each assembled word into instruction
// memory at BASE_ADDR + 4*idx. The CPU is held until the whole image is written.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, one checksum byte follows the image (also for N==0); the
//   8-bit sum of all length, data and checksum bytes must be zero, else ERR.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin a load (honoured in IDLE, DONE, ERR)
//   byte_valid_i   byte_data_i valid this cycle
//   byte_data_i    stream byte
//   byte_ready_o   loader accepts a byte this cycle
//   mem_addr_o     instruction memory write byte address (registered)
//   mem_wd_o       instruction memory write data (registered)
//   mem_write_o    write strobe, one cycle per word
//   cpu_hold_o     1 = CPU held
//   done_o         image fully written
//   err_o          load aborted
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | collecting the 4 word-count bytes
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CSUM  | (checksum build only) waiting for the checksum byte
// DONE  | image complete, CPU released
// ERR   | load aborted, CPU held

module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_write_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [31:0]        shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wd_q, wd_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               accept;
  logic [31:0]        word_next;
  logic [IDX_W-1:0]   idx_inc;

  // Outputs are pure decodes of the registered state.
  always_comb begin
    byte_ready_o = 1'b0;
    mem_write_o  = 1'b0;
    cpu_hold_o   = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (state_q)
      S_LEN, S_DATA: byte_ready_o = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM:        byte_ready_o = 1'b1;
`endif
      S_WRITE:       mem_write_o  = 1'b1;
      S_DONE: begin
        done_o     = 1'b1;
        cpu_hold_o = 1'b0;
      end
      S_ERR:         err_o        = 1'b1;
      default: ;
    endcase
  end

  assign accept     = byte_valid_i & byte_ready_o;
  // Little-endian assembly: bytes shift in from the top so the first byte
  // ends up in bits 7:0 after four transfers.
  assign word_next  = {byte_data_i, shift_q[31:8]};
  assign idx_inc    = idx_q + 1'b1;
  assign mem_addr_o = addr_q;
  assign mem_wd_o   = wd_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    if (accept) sum_d = sum_q + byte_data_i;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          idx_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          shift_d    = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d = word_next[IDX_W-1:0];
            idx_d = '0;
            if (word_next == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else if (word_next > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d    = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wd_d    = word_next;
            addr_d  = BASE_ADDR + (32'(idx_q) << 2);
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == len_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = ((sum_q + byte_data_i) == 8'd0) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      idx_q      <= '0;
      len_q      <= '0;
      addr_q     <= BASE_ADDR;
      wd_q       <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule
